// File: rtl/apb_master_sync_if.sv
// apb_master_sync_if: command/response port and APB bus of the APB requester.
interface apb_master_sync_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [AWIDTH-1:0] cmd_addr;
  logic [DWIDTH-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DWIDTH-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [AWIDTH-1:0] PADDR;
  logic [DWIDTH-1:0] PWDATA;
  logic [DWIDTH-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master_sync.sv
// apb_master_sync: single-outstanding APB requester with PREADY wait-state watchdog.
module apb_master_sync #(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  apb_master_sync_if.master     bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  state_t            r_state, w_next;
  logic [15:0]       r_wait;
  logic              r_psel, r_penable, r_pwrite;
  logic [AWIDTH-1:0] r_paddr;
  logic [DWIDTH-1:0] r_pwdata, r_rdata;
  logic              r_rsp_valid, r_err, r_timeout;
  logic              w_done, w_to;
  assign w_done = (r_state == ACCESS) && bus.PREADY;
  // Abort on the TIMEOUT-th consecutive low PREADY; r_wait counts samples already seen.
  assign w_to   = (r_state == ACCESS) && !bus.PREADY && (TIMEOUT != 0) && (r_wait == TO_LAST);
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && bus.cmd_valid) w_next = SETUP;
    if (r_state == SETUP) w_next = ACCESS;
    if (w_done || w_to) w_next = IDLE;
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state     <= IDLE;
      r_wait      <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_rsp_valid <= 1'b0;
      if (r_state == IDLE && bus.cmd_valid) begin
        r_paddr   <= bus.cmd_addr;
        r_pwrite  <= bus.cmd_write;
        r_pwdata  <= bus.cmd_write ? bus.cmd_wdata : '0;
        r_psel    <= 1'b1;
        r_penable <= 1'b0;
      end
      if (r_state == SETUP) begin
        r_penable <= 1'b1;
        r_wait    <= '0;
      end
      if (r_state == ACCESS && !bus.PREADY) r_wait <= r_wait + 16'(r_wait != '1);
      if (w_done || w_to) begin
        r_psel      <= 1'b0;
        r_penable   <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_err       <= w_done ? bus.PSLVERR : 1'b1;
        r_timeout   <= !w_done;
        r_rdata     <= (w_done && !r_pwrite) ? bus.PRDATA : '0;
      end
    end
  end
  assign bus.cmd_ready   = (r_state == IDLE) && !PRESET;
  assign bus.PSEL        = r_psel;
  assign bus.PENABLE     = r_penable;
  assign bus.PWRITE      = r_pwrite;
  assign bus.PADDR       = r_paddr;
  assign bus.PWDATA      = r_pwdata;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rdata;
  assign bus.rsp_err     = r_err;
  assign bus.rsp_timeout = r_timeout;
endmodule

// File: tb/tb_apb_master_sync.sv
// tb_apb_master_sync: directed vectors for the APB requester, sampled 1ns after each rising edge.
module tb_apb_master_sync;
  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  int   n_run = 0;
  int   n_fail = 0;
  apb_master_sync_if #(.DWIDTH(32), .AWIDTH(32)) bus ();
  apb_master_sync #(.DWIDTH(32), .AWIDTH(32), .TIMEOUT(16)) dut (
    .PCLK(PCLK),
    .PRESET(PRESET),
    .bus(bus)
  );
  always #5 PCLK = ~PCLK;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
  endtask
  initial begin
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b1;
    bus.PSLVERR   = 1'b0;
    step();
    step();
    check("rst_psel", bus.PSEL, 0);
    check("rst_pen", bus.PENABLE, 0);
    check("rst_paddr", bus.PADDR, 0);
    check("rst_pwdata", bus.PWDATA, 0);
    check("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 0);
    check("rst_rdata", bus.rsp_rdata, 0);
    check("rst_ready", bus.cmd_ready, 0);
    PRESET = 1'b0;
    #1;
    check("rel_ready", bus.cmd_ready, 1);
    // Zero-wait write
    issue(1'b1, 32'h10, 32'hDEADBEEF);
    step();
    bus.cmd_valid = 1'b0;
    check("w_setup", {bus.PSEL, bus.PENABLE, bus.PWRITE}, 3'b101);
    check("w_paddr", bus.PADDR, 32'h10);
    check("w_pwdata", bus.PWDATA, 32'hDEADBEEF);
    check("w_busy", bus.cmd_ready, 0);
    step();
    check("w_access", {bus.PSEL, bus.PENABLE, bus.rsp_valid}, 3'b110);
    check("w_stable", {bus.PADDR, bus.PWDATA}, {32'h10, 32'hDEADBEEF});
    step();
    check("w_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 3'b100);
    check("w_rdata", bus.rsp_rdata, 0);
    check("w_idle", {bus.PSEL, bus.PENABLE, bus.cmd_ready}, 3'b001);
    step();
    check("w_pulse", bus.rsp_valid, 0);
    check("w_hold", {bus.PADDR, bus.PWDATA}, {32'h10, 32'hDEADBEEF});
    // Read with two wait states and garbage on the wait cycles
    bus.PREADY = 1'b0;
    issue(1'b0, 32'h24, 32'hFFFF0000);
    step();
    bus.cmd_valid = 1'b0;
    check("r_pwdata", bus.PWDATA, 0);
    step();
    bus.PRDATA  = 32'hBAD0BAD0;
    bus.PSLVERR = 1'b1;
    step();
    check("r_wait1", {bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.cmd_ready}, 4'b1100);
    step();
    check("r_wait2", {bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.cmd_ready}, 4'b1100);
    bus.PREADY  = 1'b1;
    bus.PRDATA  = 32'h12345678;
    bus.PSLVERR = 1'b0;
    step();
    check("r_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 3'b100);
    check("r_rdata", bus.rsp_rdata, 32'h12345678);
    // Slave error on a read
    bus.PSLVERR = 1'b1;
    bus.PRDATA  = 32'hAAAA5555;
    issue(1'b0, 32'h30, 32'h0);
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    check("e_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 3'b110);
    check("e_rdata", bus.rsp_rdata, 32'hAAAA5555);
    check("e_ready", bus.cmd_ready, 1);
    bus.PSLVERR = 1'b0;
    // Watchdog: PREADY stuck low for 16 samples
    bus.PREADY = 1'b0;
    issue(1'b0, 32'h40, 32'h0);
    step();
    bus.cmd_valid = 1'b0;
    step();
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      step();
      n++;
    end
    check("t_cycles", n, 16);
    check("t_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 3'b111);
    check("t_rdata", bus.rsp_rdata, 0);
    check("t_bus", {bus.PSEL, bus.PENABLE}, 0);
    // PREADY rises on the 16th sample: completion wins over the watchdog
    issue(1'b0, 32'h44, 32'h0);
    step();
    bus.cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 15; i++) step();
    check("t16_wait", {bus.rsp_valid, bus.PSEL, bus.PENABLE}, 3'b011);
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h0BADF00D;
    step();
    check("t16_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 3'b100);
    check("t16_rdata", bus.rsp_rdata, 32'h0BADF00D);
    step();
    // Back-to-back with cmd_valid held high
    for (int i = 0; i < 4; i++) begin
      issue(i[0] == 1'b0, 32'h100 + 32'(i * 4), 32'hC0DE0000 + 32'(i));
      bus.PRDATA = 32'h5500 + 32'(i);
      check($sformatf("b%0d_ready", i), bus.cmd_ready, 1);
      step();
      check($sformatf("b%0d_setup", i), {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.cmd_ready}, {3'b101 ^ {2'b00, i[0]}, 1'b0});
      check($sformatf("b%0d_addr", i), bus.PADDR, 32'h100 + 32'(i * 4));
      step();
      step();
      check($sformatf("b%0d_rsp", i), {bus.rsp_valid, bus.PSEL}, 2'b10);
      check($sformatf("b%0d_rdata", i), bus.rsp_rdata, i[0] ? 32'h5500 + 32'(i) : 32'h0);
    end
    bus.cmd_valid = 1'b0;
    step();
    // Reset during a stalled ACCESS
    bus.PREADY = 1'b0;
    issue(1'b1, 32'h200, 32'h11223344);
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    check("x_access", {bus.PSEL, bus.PENABLE}, 2'b11);
    PRESET = 1'b1;
    step();
    check("x_bus", {bus.PSEL, bus.PENABLE, bus.PWRITE}, 0);
    check("x_addr", {bus.PADDR, bus.PWDATA}, 0);
    check("x_rsp", bus.rsp_valid, 0);
    PRESET = 1'b0;
    #1;
    check("x_ready", bus.cmd_ready, 1);
    step();
    step();
    check("x_norsp", {bus.rsp_valid, bus.PSEL}, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
